// File: rtl/cell_op_scheduler_pkg.sv
// Shared opcode encoding, scheduler state encoding and operand-count helper
// for the cell processing path.
package cell_op_scheduler_pkg;

  localparam int unsigned OPCODE_ENC_W = 4;
  localparam int unsigned NUM_OPCODES  = 12;

  typedef enum logic [OPCODE_ENC_W-1:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_MULT  = 4'd2,
    OP_AND   = 4'd3,
    OP_OR    = 4'd4,
    OP_NOR   = 4'd5,
    OP_ADDI  = 4'd6,
    OP_SUBI  = 4'd7,
    OP_MULTI = 4'd8,
    OP_DIV2  = 4'd9,
    OP_INV   = 4'd10,
    OP_AVG   = 4'd11
  } opcodes_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  // Two-image opcodes fetch image B alongside image A.
  function automatic logic needs_image_b(input opcodes_t op);
    case (op)
      OP_ADD, OP_SUB, OP_MULT, OP_AND, OP_OR, OP_NOR: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cell_op_scheduler_if.sv
// Host instruction, cell request and result-return signals of the scheduler.
// master = scheduler side, slave = host / cell pipeline side.
interface cell_op_scheduler_if #(
  parameter int unsigned IMG_W    = 640,
  parameter int unsigned IMG_H    = 480,
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned CH_W     = 8
);
  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);

  logic                instr_valid;
  logic                instr_ready;
  logic [OPCODE_W-1:0] instr_opcode;
  logic [CH_W-1:0]     instr_user;
  logic                cell_req_valid;
  logic                cell_req_ready;
  logic [XW-1:0]       cell_req_x;
  logic [YW-1:0]       cell_req_y;
  logic                cell_req_dual;
  logic [OPCODE_W-1:0] cell_req_opcode;
  logic [CH_W-1:0]     cell_req_user;
  logic                res_valid;
  logic                busy;
  logic                done;
  logic                err_opcode;

  modport master (
    input  instr_valid, instr_opcode, instr_user, cell_req_ready, res_valid,
    output instr_ready, cell_req_valid, cell_req_x, cell_req_y, cell_req_dual,
           cell_req_opcode, cell_req_user, busy, done, err_opcode
  );

  modport slave (
    output instr_valid, instr_opcode, instr_user, cell_req_ready, res_valid,
    input  instr_ready, cell_req_valid, cell_req_x, cell_req_y, cell_req_dual,
           cell_req_opcode, cell_req_user, busy, done, err_opcode
  );

endinterface

// File: rtl/cell_op_scheduler_coord.sv
// Raster-order top-left cell coordinate counter, x fastest; last flags the
// final valid cell position of the frame.
module cell_coord_counter #(
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480,
  parameter int unsigned CELL_N = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       adv,
  output logic [$clog2(IMG_W)-1:0]   x,
  output logic [$clog2(IMG_H)-1:0]   y,
  output logic                       last
);
  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);
  localparam logic [XW-1:0] XMAX = XW'(IMG_W - CELL_N);
  localparam logic [YW-1:0] YMAX = YW'(IMG_H - CELL_N);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (adv) begin
      if (x == XMAX) begin
        x <= '0;
        y <= (y == YMAX) ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  assign last = (x == XMAX) && (y == YMAX);

endmodule

// File: rtl/cell_op_scheduler.sv
// Sequences one instruction over every cell position of the frame, limiting
// cells in flight with a credit counter and signalling completion.
module cell_op_scheduler
  import cell_op_scheduler_pkg::*;
#(
  parameter int unsigned IMG_W     = 640,
  parameter int unsigned IMG_H     = 480,
  parameter int unsigned CELL_N    = 3,
  parameter int unsigned OPCODE_W  = 4,
  parameter int unsigned CH_W      = 8,
  parameter int unsigned MAX_OUTST = 4
) (
  input logic                 clk,
  input logic                 rst,
  cell_op_scheduler_if.master bus
);
  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);
  localparam int unsigned CW = $clog2(MAX_OUTST + 1);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_DRAIN = DRAIN;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]    state, state_d;
  logic [CW-1:0] outst, outst_d;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          last;
  logic          accept, illegal, hs, dec;

  assign accept  = bus.instr_valid && bus.instr_ready;
  assign illegal = bus.instr_opcode >= OPCODE_W'(NUM_OPCODES);
  assign hs      = bus.cell_req_valid && bus.cell_req_ready;
  // Returns with no cell in flight are stray and must not wrap the counter.
  assign dec     = bus.res_valid && (outst != '0);

  cell_coord_counter #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .CELL_N (CELL_N)
  ) u_coord (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .adv  (hs),
    .x    (x),
    .y    (y),
    .last (last)
  );

  assign bus.cell_req_x = x;
  assign bus.cell_req_y = y;

  // Next state and next credit count; DRAIN exits on the edge where the count hits zero.
  always_comb begin
    state_d = state;
    outst_d = outst;
    if (hs && !dec) begin
      outst_d = outst + CW'(1);
    end else if (!hs && dec) begin
      outst_d = outst - CW'(1);
    end
    case (state)
      ST_IDLE:  if (accept && !illegal) state_d = ST_ISSUE;
      ST_ISSUE: if (hs && last)         state_d = ST_DRAIN;
      ST_DRAIN: if (outst_d == '0)      state_d = ST_DONE;
      ST_DONE:                          state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  // State, credits and status outputs, all registered from next-state values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= ST_IDLE;
      outst              <= '0;
      bus.instr_ready    <= 1'b0;
      bus.cell_req_valid <= 1'b0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.err_opcode     <= 1'b0;
    end else begin
      state              <= state_d;
      outst              <= outst_d;
      bus.instr_ready    <= (state_d == ST_IDLE);
      bus.cell_req_valid <= (state_d == ST_ISSUE) && (outst_d < CW'(MAX_OUTST));
      bus.busy           <= (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
      bus.done           <= (state_d == ST_DONE);
      bus.err_opcode     <= accept && illegal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.cell_req_opcode <= '0;
      bus.cell_req_user   <= '0;
      bus.cell_req_dual   <= 1'b0;
    end else if (accept && !illegal) begin
      bus.cell_req_opcode <= bus.instr_opcode;
      bus.cell_req_user   <= bus.instr_user;
      bus.cell_req_dual   <= needs_image_b(opcodes_t'(OPCODE_ENC_W'(bus.instr_opcode)));
    end
  end

endmodule

// File: tb/tb_cell_op_scheduler.sv
// Scoreboard bench for cell_op_scheduler on a 4x4 frame with 3x3 cells:
// one instance with four credits, one with two.
module tb_cell_op_scheduler;
  import cell_op_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cell_op_scheduler_if #(.IMG_W(4), .IMG_H(4)) bus_a ();
  cell_op_scheduler_if #(.IMG_W(4), .IMG_H(4)) bus_b ();

  cell_op_scheduler #(.IMG_W(4), .IMG_H(4), .CELL_N(3), .MAX_OUTST(4)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a));
  cell_op_scheduler #(.IMG_W(4), .IMG_H(4), .CELL_N(3), .MAX_OUTST(2)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b));

  typedef struct packed {
    logic [1:0] x;
    logic [1:0] y;
    logic       dual;
    logic [3:0] op;
    logic [7:0] user;
  } req_t;

  req_t exp_a[$];
  req_t exp_b[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int req_cnt_a = 0, req_cnt_b = 0, done_cnt_a = 0, done_cnt_b = 0;
  int err_cnt_a = 0, busy_cnt_a = 0, valid_cnt_a = 0;
  int first_hs = -1, last_hs = -1, done_cyc = -1, last_res_cyc = -1;
  logic hs_a = 1'b0, rand_mode = 1'b0, rdy_fix = 1'b1, resp_en = 1'b0, res_force = 1'b0;
  logic [2:0] dl = 3'b0;
  logic       stall_q = 1'b0;
  logic [1:0] stall_x, stall_y;
  logic [3:0] stall_op;
  logic [7:0] stall_user;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Ready driver and fixed-latency result responder for instance A.
  always @(posedge clk) begin
    cyc++;
    #1;
    bus_a.cell_req_ready = rand_mode ? 1'($urandom_range(0, 1)) : rdy_fix;
    bus_a.res_valid      = (resp_en && dl[1]) || res_force;
    dl                   = resp_en ? {dl[1:0], hs_a} : 3'b0;
  end

  // Monitor A: pops the scoreboard on every handshake, checks stall stability.
  always @(negedge clk) begin : mon_a
    req_t e;
    if (rst) begin
      hs_a    = 1'b0;
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("stall_valid_held", int'(bus_a.cell_req_valid), 1);
        chk("stall_x_stable", int'(bus_a.cell_req_x), int'(stall_x));
        chk("stall_y_stable", int'(bus_a.cell_req_y), int'(stall_y));
        chk("stall_op_stable", int'(bus_a.cell_req_opcode), int'(stall_op));
        chk("stall_user_stable", int'(bus_a.cell_req_user), int'(stall_user));
      end
      hs_a = bus_a.cell_req_valid && bus_a.cell_req_ready;
      if (bus_a.cell_req_valid) valid_cnt_a++;
      if (hs_a) begin
        req_cnt_a++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        if (exp_a.size() == 0) begin
          chk("a_unexpected_req", 1, 0);
        end else begin
          e = exp_a.pop_front();
          chk("a_req_x", int'(bus_a.cell_req_x), int'(e.x));
          chk("a_req_y", int'(bus_a.cell_req_y), int'(e.y));
          chk("a_req_dual", int'(bus_a.cell_req_dual), int'(e.dual));
          chk("a_req_opcode", int'(bus_a.cell_req_opcode), int'(e.op));
          chk("a_req_user", int'(bus_a.cell_req_user), int'(e.user));
        end
      end
      stall_q    = bus_a.cell_req_valid && !bus_a.cell_req_ready;
      stall_x    = bus_a.cell_req_x;
      stall_y    = bus_a.cell_req_y;
      stall_op   = bus_a.cell_req_opcode;
      stall_user = bus_a.cell_req_user;
      if (bus_a.res_valid) last_res_cyc = cyc;
      if (bus_a.done) begin
        done_cnt_a++;
        done_cyc = cyc;
      end
      if (bus_a.err_opcode) err_cnt_a++;
      if (bus_a.busy) busy_cnt_a++;
    end
  end

  always @(negedge clk) begin : mon_b
    req_t e;
    if (!rst) begin
      if (bus_b.cell_req_valid && bus_b.cell_req_ready) begin
        req_cnt_b++;
        if (exp_b.size() == 0) begin
          chk("b_unexpected_req", 1, 0);
        end else begin
          e = exp_b.pop_front();
          chk("b_req_x", int'(bus_b.cell_req_x), int'(e.x));
          chk("b_req_y", int'(bus_b.cell_req_y), int'(e.y));
          chk("b_req_dual", int'(bus_b.cell_req_dual), int'(e.dual));
        end
      end
      if (bus_b.done) done_cnt_b++;
    end
  end

  task automatic push_frame(input logic b_side, input logic d, input opcodes_t op,
                            input logic [7:0] u);
    req_t e;
    for (int yy = 0; yy < 2; yy++) begin
      for (int xx = 0; xx < 2; xx++) begin
        e.x = 2'(xx); e.y = 2'(yy); e.dual = d; e.op = 4'(op); e.user = u;
        if (b_side) exp_b.push_back(e);
        else        exp_a.push_back(e);
      end
    end
  endtask

  task automatic send_a(input logic [3:0] op, input logic [7:0] u);
    int n = 0;
    while (!bus_a.instr_ready && n < 50) begin
      tick(1);
      n++;
    end
    chk("a_instr_ready_wait", int'(bus_a.instr_ready), 1);
    bus_a.instr_opcode = op;
    bus_a.instr_user   = u;
    bus_a.instr_valid  = 1'b1;
    tick(1);
    bus_a.instr_valid  = 1'b0;
  endtask

  task automatic run_a(input string tag, input logic d, input opcodes_t op,
                       input logic [7:0] u, input logic timing);
    int r0, d0, n;
    r0 = req_cnt_a;
    d0 = done_cnt_a;
    n  = 0;
    first_hs = -1;
    push_frame(1'b0, d, op, u);
    send_a(4'(op), u);
    while (!bus_a.done && n < 300) begin
      tick(1);
      n++;
    end
    chk({tag, "_done_seen"}, int'(bus_a.done), 1);
    chk({tag, "_ready_low_at_done"}, int'(bus_a.instr_ready), 0);
    chk({tag, "_busy_low_at_done"}, int'(bus_a.busy), 0);
    tick(1);
    chk({tag, "_ready_after_done"}, int'(bus_a.instr_ready), 1);
    chk({tag, "_done_one_cycle"}, int'(bus_a.done), 0);
    tick(2);
    chk({tag, "_req_count"}, req_cnt_a - r0, 4);
    chk({tag, "_done_count"}, done_cnt_a - d0, 1);
    chk({tag, "_queue_empty"}, exp_a.size(), 0);
    if (timing) begin
      chk({tag, "_consecutive_reqs"}, last_hs - first_hs, 3);
      chk({tag, "_done_after_last_res"}, done_cyc - last_res_cyc, 1);
    end
  endtask

  initial begin
    int e0, b0, v0, r0;
    rst = 1'b1;
    bus_a.instr_valid = 1'b0; bus_a.instr_opcode = '0; bus_a.instr_user = '0;
    bus_b.instr_valid = 1'b0; bus_b.instr_opcode = '0; bus_b.instr_user = '0;
    bus_b.cell_req_ready = 1'b1; bus_b.res_valid = 1'b0;
    tick(3);
    chk("rst_instr_ready", int'(bus_a.instr_ready), 0);
    chk("rst_req_valid", int'(bus_a.cell_req_valid), 0);
    chk("rst_busy", int'(bus_a.busy), 0);
    chk("rst_done", int'(bus_a.done), 0);
    chk("rst_err", int'(bus_a.err_opcode), 0);
    rst = 1'b0;
    tick(1);
    chk("ready_after_rst", int'(bus_a.instr_ready), 1);

    // Two-credit instance: exactly two requests until a result returns.
    push_frame(1'b1, 1'b0, OP_ADDI, 8'h22);
    bus_b.instr_opcode = 4'(OP_ADDI);
    bus_b.instr_user   = 8'h22;
    bus_b.instr_valid  = 1'b1;
    tick(1);
    bus_b.instr_valid  = 1'b0;
    tick(8);
    chk("b_two_credits", req_cnt_b, 2);
    chk("b_valid_low_no_credit", int'(bus_b.cell_req_valid), 0);
    bus_b.res_valid = 1'b1;
    tick(1);
    bus_b.res_valid = 1'b0;
    tick(6);
    chk("b_one_more_req", req_cnt_b, 3);
    chk("b_valid_low_again", int'(bus_b.cell_req_valid), 0);
    repeat (3) begin
      bus_b.res_valid = 1'b1;
      tick(1);
      bus_b.res_valid = 1'b0;
      tick(3);
    end
    tick(3);
    chk("b_req_total", req_cnt_b, 4);
    chk("b_done_count", done_cnt_b, 1);
    chk("b_busy_idle", int'(bus_b.busy), 0);

    rdy_fix = 1'b1;
    resp_en = 1'b1;
    run_a("addi", 1'b0, OP_ADDI, 8'h10, 1'b1);
    run_a("add", 1'b1, OP_ADD, 8'h55, 1'b1);
    rand_mode = 1'b1;
    run_a("rand_ready", 1'b0, OP_MULTI, 8'hA5, 1'b0);
    rand_mode = 1'b0;
    tick(2);

    // Undefined opcode: error pulse only.
    e0 = err_cnt_a; b0 = busy_cnt_a; v0 = valid_cnt_a;
    send_a(4'd13, 8'h77);
    tick(6);
    chk("illegal_err_pulses", err_cnt_a - e0, 1);
    chk("illegal_no_busy", busy_cnt_a - b0, 0);
    chk("illegal_no_valid", valid_cnt_a - v0, 0);
    chk("illegal_ready_high", int'(bus_a.instr_ready), 1);

    // Asynchronous reset mid-frame after two requests.
    resp_en = 1'b0;
    r0 = req_cnt_a;
    exp_a.push_back('{x: 2'd0, y: 2'd0, dual: 1'b1, op: 4'(OP_SUB), user: 8'h3C});
    exp_a.push_back('{x: 2'd1, y: 2'd0, dual: 1'b1, op: 4'(OP_SUB), user: 8'h3C});
    send_a(4'(OP_SUB), 8'h3C);
    begin
      int n = 0;
      while (req_cnt_a < r0 + 2 && n < 50) begin
        tick(1);
        n++;
      end
    end
    chk("mid_reqs_before_rst", req_cnt_a - r0, 2);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", int'(bus_a.cell_req_valid), 0);
    chk("async_rst_busy", int'(bus_a.busy), 0);
    chk("async_rst_ready", int'(bus_a.instr_ready), 0);
    chk("async_rst_x", int'(bus_a.cell_req_x), 0);
    chk("async_rst_y", int'(bus_a.cell_req_y), 0);
    chk("async_rst_queue", exp_a.size(), 0);
    tick(2);
    rst = 1'b0;
    tick(2);
    res_force = 1'b1;
    tick(1);
    res_force = 1'b0;
    tick(3);
    resp_en = 1'b1;
    run_a("after_rst", 1'b1, OP_SUB, 8'h3C, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/cell_op_scheduler.md
Name: cell_op_scheduler

Overview:
- Sequences one image-processing instruction across a whole frame.
- Accepts an instruction (opcode plus user immediate) via valid/ready, then raster-scans every valid cell position. For each position it issues one cell request, carrying the opcode, to the cell fetch/processor path.
- Limits in-flight cells with a credit counter. Declares the instruction complete once every issued cell's result has returned.
- Sits between the host instruction interface and the cell processor pipeline.

Parameters:
- IMG_W, 640, input image width in pixels
- IMG_H, 480, input image height in pixels
- CELL_N, 3, cell edge length in pixels
- OPCODE_W, 4, opcode width
- CH_W, 8, user immediate width (one colour channel)
- MAX_OUTST, 4, maximum cells in flight (must be ≥1)
- XW, $clog2(IMG_W), x coordinate width
- YW, $clog2(IMG_H), y coordinate width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  scheduler can accept an instruction
- instr_opcode  in  OPCODE_W  opcode (opcodes_t encoding)
- instr_user  in  CH_W  user immediate
- cell_req_valid  out  1  cell request valid
- cell_req_ready  in  1  downstream accepts request
- cell_req_x  out  XW  top-left x of cell
- cell_req_y  out  YW  top-left y of cell
- cell_req_dual  out  1  cell needs image B as well as image A
- cell_req_opcode  out  OPCODE_W  latched opcode
- cell_req_user  out  CH_W  latched immediate
- res_valid  in  1  one cell result retired (returns one credit)
- busy  out  1  instruction in progress
- done  out  1  one-cycle pulse when an instruction completes
- err_opcode  out  1  one-cycle pulse when an illegal opcode is accepted

Behaviour:
- Reset values: instr_ready=0, cell_req_valid=0, busy=0, done=0, err_opcode=0, x=y=0, outstanding=0, state=IDLE. Reset at any time, including mid-frame, aborts the instruction and discards credits; late res_valid after reset is ignored.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - instr_ready=1 only in this state.
  - On instr_valid&&instr_ready, latch opcode and immediate.
  - Set dual=1 for ADD, SUB, MULT, AND, OR, NOR; dual=0 for ADDI, SUBI, MULTI, DIV2, INV, AVG.
  - If opcode ≥ 12 (undefined), pulse err_opcode next cycle and stay IDLE; no cells are issued.
  - Otherwise go to ISSUE with x=y=0.
- ISSUE:
  - busy=1.
  - cell_req_valid = (outstanding < MAX_OUTST), so the first request appears the cycle after accept.
  - Once valid is asserted, payload holds stable until ready; valid never drops without a handshake.
  - On each handshake, advance in raster order with x fastest: x runs 0..IMG_W-CELL_N, then x returns to 0 and y increments; y runs 0..IMG_H-CELL_N.
  - Total cells per instruction: (IMG_W-CELL_N+1)*(IMG_H-CELL_N+1), which is 638*478 at defaults.
  - The handshake on the last position (x=IMG_W-CELL_N, y=IMG_H-CELL_N) moves to DRAIN.
- Outstanding counter:
  - +1 on request handshake, −1 on res_valid; both in the same cycle leaves it unchanged.
  - res_valid when outstanding=0 is ignored; the counter saturates at 0.
  - Never exceeds MAX_OUTST.
- DRAIN: busy=1, cell_req_valid=0; move to DONE when outstanding=0. This includes the cycle where the final res_valid lands (counter reaches 0, transition on the next edge).
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. instr_ready returns the cycle after done.
- Throughput: one cell per cycle while credits are available and cell_req_ready=1.

Decomposition:
- Shared package CellProcessingPkg gains:
  - a function needs_image_b(opcodes_t) returning the dual flag;
  - the enum sched_state_t {IDLE, ISSUE, DRAIN, DONE};
  - the constant NUM_OPCODES=12 used for legality checks.
- One sub-module, cell_coord_counter: raster x/y counter with parameters IMG_W, IMG_H, CELL_N, inputs clr and adv, outputs x, y and last.

Test Plan:
- IMG_W=4, IMG_H=4, CELL_N=3, MAX_OUTST=4, ready held high, res_valid 3 cycles after each request, ADDI user=0x10:
  - requests (0,0),(1,0),(0,1),(1,1) on 4 consecutive cycles with dual=0 and user=0x10;
  - done pulses once, 1 cycle after the 4th result.
- Same image size with ADD (opcode 0): every request has dual=1 and opcode=0.
- MAX_OUTST=2, res_valid withheld: exactly 2 requests issue, then valid stays low; one res_valid leads to exactly one more request.
- cell_req_ready toggled randomly: x/y/opcode stay stable while valid&&!ready; no position is skipped or repeated; the total is 4.
- instr_opcode=13 accepted: err_opcode pulses once, busy stays 0, no cell_req_valid, instr_ready stays 1.
- rst asserted mid-ISSUE after 2 requests: all outputs return to reset values asynchronously; a new instruction restarts at (0,0); res_valid arriving during IDLE is ignored.
